dual_port_data_memory: RTL and testbench
========================================

Name: dual_port_data_memory

Overview:
- Word-addressed data memory serving the two MEM-stage lanes of the superscalar MIPS core.
- Answers the core's loads and stores.
- Also has a result-dump reader port. Benches and debug logic use it to stream a region of memory out over a valid/ready handshake, instead of probing internal words hierarchically.
- Sits beside the core at top level. The dump port is the read-side counterpart of the core's store traffic.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; must be a power of two.
- ADDR_W, 8, log2(DEPTH_WORDS); word-index width.
- SEED0, 0, reset value of word 0 (first Fibonacci seed).
- SEED1, 1, reset value of word 1 (second Fibonacci seed).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- a_mem_read  in  1  lane A (older instruction) load enable.
- a_mem_write  in  1  lane A store enable.
- a_addr  in  32  lane A byte address.
- a_write_data  in  32  lane A store data.
- a_read_data  out  32  lane A load data.
- b_mem_read  in  1  lane B (younger instruction) load enable.
- b_mem_write  in  1  lane B store enable.
- b_addr  in  32  lane B byte address.
- b_write_data  in  32  lane B store data.
- b_read_data  out  32  lane B load data.
- dump_start  in  1  one-cycle request to begin a dump.
- dump_base  in  ADDR_W  first word index to stream.
- dump_count  in  ADDR_W+1  number of words to stream (0..DEPTH_WORDS).
- dump_valid  out  1  dump beat available.
- dump_ready  in  1  consumer accepts beat.
- dump_data  out  32  beat data.
- dump_index  out  ADDR_W  word index of current beat.
- dump_busy  out  1  dump FSM not IDLE.
- dump_done  out  1  one-cycle pulse after last beat, or for a zero-count dump.

Behaviour:
- Reset (synchronous, active-high):
  - word0 <= SEED0, word1 <= SEED1, all other words <= 0.
  - FSM <= IDLE.
  - dump_valid, dump_busy, dump_done <= 0; dump_data, dump_index <= 0.
  - Reset mid-dump aborts the dump with no dump_done.
- Addressing: word index = addr[ADDR_W+1:2]. addr[1:0] and upper bits are ignored, so out-of-range addresses wrap modulo DEPTH_WORDS.
- Loads:
  - Combinational: x_read_data = mem[index] in the same cycle.
  - Read data is 0 when x_mem_read = 0.
  - Same-cycle store to the same word is not forwarded; the load returns the pre-edge value.
- Stores: write on rising edge when x_mem_write = 1.
- Both lanes storing the same word in one cycle: lane B wins, matching program order.
- Dump FSM states are IDLE, STREAM, DONE.
- IDLE:
  - dump_start with count = 0 -> DONE.
  - dump_start with count > 0 -> STREAM. Latch ptr = base and remaining = count; snapshot dump_data <= mem[base], dump_index <= base.
  - dump_start is ignored in every other state.
- STREAM:
  - dump_valid = 1.
  - dump_data and dump_index stay stable while dump_ready = 0, even if the core writes that word; data is a snapshot.
  - On valid & ready: remaining-1 = 0 -> DONE. Otherwise ptr <= ptr+1 (wraps at DEPTH_WORDS) and re-snapshot mem[ptr+1].
  - A snapshot taken in the same cycle as a core store to that word captures the pre-store value.
- DONE: dump_done = 1 and dump_valid = 0 for exactly one cycle, then IDLE.
- dump_busy = (state != IDLE).
- Latency: start at cycle t -> first dump_valid at t+1. With ready held high, N beats occupy t+1..t+N and dump_done is at t+N+1.

Decomposition:
- Shared package mips_mem_pkg: DEPTH_WORDS/ADDR_W defaults, word-index extraction function, dump FSM state enum (IDLE/STREAM/DONE).
- One sub-module, mem_dump_reader: the dump FSM plus its snapshot registers.
  - Interface: a read-address output and a combinational data input from the array.
- The storage array and lane write arbitration stay in the top module.

Test Plan:
- Reset then read: load from addresses 0x0 and 0x4 on lanes A/B -> a_read_data = 0, b_read_data = 1. Load from 0x8 -> 0.
- Fibonacci fill then dump:
  - Store 1,2,3,5,8,13,21,34,55,89 to byte addresses 0x8..0x2C, alternating lanes.
  - dump_start at cycle t with base = 2, count = 10, ready held high.
  - Expect 10 beats at t+1..t+10 with data 1..89 and index 2..11; dump_done pulse at t+11; busy high t+1..t+11.
- Backpressure:
  - Same dump with ready low for 3 cycles on beat 4, and a core store of 999 to word 5 during the stall.
  - dump_data holds 5 throughout the stall.
  - Next beat reads 999 at index 6? No: word 6 is unaffected, so the beat is 8. A later re-dump shows 999 at index 5.
- Lane conflict:
  - Same cycle: A stores 0x11 and B stores 0x22 to 0x40 -> next cycle word 16 reads 0x22.
  - Same-cycle load of 0x40 on either lane during the write returns the old value.
- Edge dumps:
  - count = 0 -> dump_done at t+1, no valid.
  - base = 255, count = 3 -> indices 255, 0, 1.
  - dump_start while busy is ignored.
- Reset mid-dump: assert reset during beat 3 -> next cycle valid = 0, busy = 0, no dump_done; word 2 reads 0 afterward.

Source files
------------

// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_pkg
// Description : Shared sizing constants, dump FSM state type and the
//               byte-to-word address helper for the MIPS data memory.
// Revision    : 1.0
// ============================================================================
package mips_mem_pkg;

    localparam int c_DEPTH_WORDS = 256;
    localparam int c_ADDR_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } dump_state_t;

    // Callers truncate the result to their own index width, which gives the
    // modulo-DEPTH wrap for out-of-range addresses.
    function automatic logic [31:0] word_of(input logic [31:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : mem_dump_reader
// Description : Streams a region of the data memory out over valid/ready,
//               one snapshotted word per beat.
// Revision    : 1.0
// ============================================================================
module mem_dump_reader
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W:0]   i_count,
    input  logic              i_ready,
    output logic [ADDR_W-1:0] o_raddr,
    input  logic [31:0]       i_rdata,
    output logic              o_valid,
    output logic [31:0]       o_data,
    output logic [ADDR_W-1:0] o_index,
    output logic              o_busy,
    output logic              o_done
);

    dump_state_t       r_state;
    dump_state_t       w_state_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_next;
    logic [ADDR_W:0]   r_rem;
    logic [ADDR_W:0]   w_rem_next;
    logic [31:0]       r_data;
    logic              w_load;
    logic [ADDR_W-1:0] w_raddr;

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_rem_next   = r_rem;
        w_load       = 1'b0;
        w_raddr      = r_ptr + ADDR_W'(1);
        case (r_state)
            ST_IDLE: begin
                w_raddr = i_base;
                if (i_start) begin
                    if (i_count == '0) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_STREAM;
                        w_ptr_next   = i_base;
                        w_rem_next   = i_count;
                        w_load       = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                if (i_ready) begin
                    if (r_rem == (ADDR_W+1)'(1)) begin
                        w_state_next = ST_DONE;
                    end else begin
                        // The array read is combinational, so the snapshot
                        // taken at this edge sees the pre-store value.
                        w_ptr_next = r_ptr + ADDR_W'(1);
                        w_rem_next = r_rem - (ADDR_W+1)'(1);
                        w_load     = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_rem   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_rem   <= w_rem_next;
            if (w_load) begin
                r_data <= i_rdata;
            end
        end
    end

    assign o_raddr = w_raddr;
    assign o_valid = (r_state == ST_STREAM);
    assign o_data  = r_data;
    assign o_index = r_ptr;
    assign o_busy  = (r_state != ST_IDLE);
    assign o_done  = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: rtl/dual_port_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : dual_port_data_memory
// Description : Two-lane word-addressed data memory with a result-dump port.
// Revision    : 1.0
// ============================================================================
module dual_port_data_memory
    import mips_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = c_DEPTH_WORDS,
    parameter int          ADDR_W      = c_ADDR_W,
    parameter logic [31:0] SEED0       = 32'd0,
    parameter logic [31:0] SEED1       = 32'd1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_mem_read,
    input  logic              a_mem_write,
    input  logic [31:0]       a_addr,
    input  logic [31:0]       a_write_data,
    output logic [31:0]       a_read_data,
    input  logic              b_mem_read,
    input  logic              b_mem_write,
    input  logic [31:0]       b_addr,
    input  logic [31:0]       b_write_data,
    output logic [31:0]       b_read_data,
    input  logic              dump_start,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [ADDR_W:0]   dump_count,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [31:0]       dump_data,
    output logic [ADDR_W-1:0] dump_index,
    output logic              dump_busy,
    output logic              dump_done
);

    logic [31:0]       r_mem [DEPTH_WORDS];
    logic [ADDR_W-1:0] w_a_idx;
    logic [ADDR_W-1:0] w_b_idx;
    logic [ADDR_W-1:0] w_dump_raddr;

    assign w_a_idx = ADDR_W'(word_of(a_addr));
    assign w_b_idx = ADDR_W'(word_of(b_addr));

    // Lane B is the younger instruction, so its store is issued last and wins
    // a same-word collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= (i == 0) ? SEED0 : (i == 1) ? SEED1 : 32'd0;
            end
        end else begin
            if (a_mem_write) begin
                r_mem[w_a_idx] <= a_write_data;
            end
            if (b_mem_write) begin
                r_mem[w_b_idx] <= b_write_data;
            end
        end
    end

    assign a_read_data = a_mem_read ? r_mem[w_a_idx] : 32'd0;
    assign b_read_data = b_mem_read ? r_mem[w_b_idx] : 32'd0;

    mem_dump_reader #(
        .ADDR_W (ADDR_W)
    ) u_dump (
        .clk     (clk),
        .rst     (reset),
        .i_start (dump_start),
        .i_base  (dump_base),
        .i_count (dump_count),
        .i_ready (dump_ready),
        .o_raddr (w_dump_raddr),
        .i_rdata (r_mem[w_dump_raddr]),
        .o_valid (dump_valid),
        .o_data  (dump_data),
        .o_index (dump_index),
        .o_busy  (dump_busy),
        .o_done  (dump_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_dual_port_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_port_data_memory
// Description : Self-checking bench against a word-array reference model.
// Revision    : 1.0
// ============================================================================
module tb_dual_port_data_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_mem_read, a_mem_write, b_mem_read, b_mem_write;
    logic [31:0] a_addr, a_write_data, b_addr, b_write_data;
    logic [31:0] a_read_data, b_read_data;
    logic        dump_start, dump_ready;
    logic [7:0]  dump_base;
    logic [8:0]  dump_count;
    logic        dump_valid, dump_busy, dump_done;
    logic [31:0] dump_data;
    logic [7:0]  dump_index;

    logic [31:0] m [256];
    int n_vec = 0;
    int n_err = 0;

    dual_port_data_memory dut (
        .clk          (clk),
        .reset        (reset),
        .a_mem_read   (a_mem_read),
        .a_mem_write  (a_mem_write),
        .a_addr       (a_addr),
        .a_write_data (a_write_data),
        .a_read_data  (a_read_data),
        .b_mem_read   (b_mem_read),
        .b_mem_write  (b_mem_write),
        .b_addr       (b_addr),
        .b_write_data (b_write_data),
        .b_read_data  (b_read_data),
        .dump_start   (dump_start),
        .dump_base    (dump_base),
        .dump_count   (dump_count),
        .dump_valid   (dump_valid),
        .dump_ready   (dump_ready),
        .dump_data    (dump_data),
        .dump_index   (dump_index),
        .dump_busy    (dump_busy),
        .dump_done    (dump_done)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % 256);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge; the model applies exactly what the memory should.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            foreach (m[i]) m[i] = 32'd0;
            m[1] = 32'd1;
        end else begin
            if (a_mem_write) m[widx(a_addr)] = a_write_data;
            if (b_mem_write) m[widx(b_addr)] = b_write_data;
        end
        #1;
    endtask

    task automatic idle_lanes();
        a_mem_read = 0; a_mem_write = 0; b_mem_read = 0; b_mem_write = 0;
    endtask

    task automatic run_dump(input int base, input int count, input int stall_beat,
                            input int stall_len, input int wr_word,
                            input logic [31:0] wr_val, input bit rnd, input bit poke);
        int exp_idx;
        logic [31:0] exp_d;
        int beat;
        int cyc;
        int stall_left;
        idle_lanes();
        dump_base = 8'(base); dump_count = 9'(count); dump_start = 1; dump_ready = 1;
        exp_idx = base % 256;
        exp_d = m[exp_idx];
        step();
        dump_start = 0; dump_base = 0; dump_count = 0;
        if (count > 0) begin
            beat = 0; cyc = 0; stall_left = stall_len;
            while (beat < count && cyc < 40 * count + 40) begin
                idle_lanes();
                dump_start = 0;
                if (beat == stall_beat && stall_left > 0) begin
                    dump_ready = 0;
                    if (stall_left == stall_len && wr_word >= 0) begin
                        a_mem_write = 1; a_addr = 32'(wr_word * 4); a_write_data = wr_val;
                    end
                    stall_left--;
                end else if (rnd) begin
                    dump_ready = 1'($urandom_range(0, 1));
                end else begin
                    dump_ready = 1;
                end
                if (rnd) begin
                    b_mem_write = 1'($urandom_range(0, 1));
                    b_addr = $urandom; b_write_data = $urandom;
                end
                if (poke && beat == 1) begin
                    dump_start = 1; dump_base = 8'd7; dump_count = 9'd1;
                end
                #1;
                chk("beat_valid", 32'(dump_valid), 32'd1);
                chk("beat_index", 32'(dump_index), 32'(exp_idx));
                chk("beat_data", dump_data, exp_d);
                chk("beat_busy", 32'(dump_busy), 32'd1);
                chk("beat_done", 32'(dump_done), 32'd0);
                if (dump_ready) begin
                    beat++;
                    if (beat < count) begin
                        exp_idx = (exp_idx + 1) % 256;
                        exp_d = m[exp_idx];
                    end
                end
                step();
                cyc++;
            end
            chk("dump_budget", 32'(beat), 32'(count));
        end
        idle_lanes();
        dump_start = 0;
        if (poke) begin
            dump_start = 1; dump_base = 8'd9; dump_count = 9'd2;
        end
        #1;
        chk("done_pulse", 32'(dump_done), 32'd1);
        chk("done_valid", 32'(dump_valid), 32'd0);
        chk("done_busy", 32'(dump_busy), 32'd1);
        step();
        dump_start = 0;
        #1;
        chk("post_done", 32'(dump_done), 32'd0);
        chk("post_busy", 32'(dump_busy), 32'd0);
        chk("post_valid", 32'(dump_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] fib [10];
        logic [31:0] old;
        fib = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 89};
        reset = 1; idle_lanes();
        a_addr = 0; b_addr = 0; a_write_data = 0; b_write_data = 0;
        dump_start = 0; dump_base = 0; dump_count = 0; dump_ready = 0;
        step(); step();
        reset = 0;

        // Reset contents and idle dump outputs.
        a_mem_read = 1; a_addr = 32'h0; b_mem_read = 1; b_addr = 32'h4;
        #1;
        chk("rst_word0", a_read_data, 32'd0);
        chk("rst_word1", b_read_data, 32'd1);
        a_addr = 32'h8; b_mem_read = 0;
        #1;
        chk("rst_word2", a_read_data, 32'd0);
        chk("rd_disabled", b_read_data, 32'd0);
        chk("rst_valid", 32'(dump_valid), 32'd0);
        chk("rst_busy", 32'(dump_busy), 32'd0);
        chk("rst_done", 32'(dump_done), 32'd0);
        chk("rst_data", dump_data, 32'd0);
        chk("rst_index", 32'(dump_index), 32'd0);

        // Fibonacci fill, alternating lanes.
        for (int i = 0; i < 10; i++) begin
            idle_lanes();
            if (i % 2 == 0) begin
                a_mem_write = 1; a_addr = 32'(8 + 4 * i); a_write_data = fib[i];
            end else begin
                b_mem_write = 1; b_addr = 32'(8 + 4 * i); b_write_data = fib[i];
            end
            step();
        end
        idle_lanes();

        run_dump(2, 10, -1, 0, -1, 0, 0, 0);
        run_dump(2, 10, 3, 3, 5, 32'd999, 0, 0);
        run_dump(2, 10, -1, 0, -1, 0, 0, 0);

        // Lane conflict on word 16.
        old = m[16];
        a_mem_write = 1; a_addr = 32'h40; a_write_data = 32'h11; a_mem_read = 1;
        b_mem_write = 1; b_addr = 32'h40; b_write_data = 32'h22; b_mem_read = 1;
        #1;
        chk("conflict_old_a", a_read_data, old);
        chk("conflict_old_b", b_read_data, old);
        step();
        a_mem_write = 0; b_mem_write = 0;
        #1;
        chk("conflict_a", a_read_data, 32'h22);
        chk("conflict_b", b_read_data, m[16]);
        idle_lanes();

        // Edge dumps: empty, wrapping, start while busy.
        run_dump(0, 0, -1, 0, -1, 0, 0, 0);
        run_dump(255, 3, -1, 0, -1, 0, 0, 1);
        run_dump(250, 256, 100, 2, -1, 0, 0, 0);

        // Random two-lane traffic against the model.
        for (int k = 0; k < 300; k++) begin
            a_mem_read = 1'($urandom_range(0, 1)); a_mem_write = 1'($urandom_range(0, 1));
            b_mem_read = 1'($urandom_range(0, 1)); b_mem_write = 1'($urandom_range(0, 1));
            a_addr = $urandom; b_addr = $urandom;
            if ($urandom_range(0, 3) == 0) b_addr = a_addr ^ {24'($urandom) << 10, 8'($urandom_range(0, 3))};
            a_write_data = $urandom; b_write_data = $urandom;
            #1;
            chk("rand_a", a_read_data, a_mem_read ? m[widx(a_addr)] : 32'd0);
            chk("rand_b", b_read_data, b_mem_read ? m[widx(b_addr)] : 32'd0);
            step();
        end
        idle_lanes();

        for (int k = 0; k < 6; k++) begin
            run_dump(int'($urandom_range(0, 255)), int'($urandom_range(1, 40)), -1, 0, -1, 0, 1, k % 2);
        end

        // Reset during beat 3 aborts without a done pulse.
        dump_base = 8'd2; dump_count = 9'd10; dump_start = 1; dump_ready = 1;
        step();
        dump_start = 0;
        step(); step();
        #1;
        chk("abort_beat3", 32'(dump_index), 32'd4);
        reset = 1;
        step();
        reset = 0;
        #1;
        chk("abort_valid", 32'(dump_valid), 32'd0);
        chk("abort_busy", 32'(dump_busy), 32'd0);
        chk("abort_done", 32'(dump_done), 32'd0);
        step();
        a_mem_read = 1; a_addr = 32'h8;
        #1;
        chk("abort_done2", 32'(dump_done), 32'd0);
        chk("abort_word2", a_read_data, m[2]);
        chk("abort_word2_zero", a_read_data, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
